// File: rtl/bcd_display_driver.sv
// Tens counter and display stage for a decade counter: holds the tens digit, snapshots
// both digits on request and drives a two-digit multiplexed 7-segment display.
module bcd_display_driver #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       cp,
  input  logic       reset,
  input  logic [3:0] ones_bcd,
  input  logic       carry_in,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] tens_bcd,
  output logic       ovf,
  output logic       bcd_err
);

  // state     | meaning
  // SHOW_ONES | ones digit enabled (an=01)
  // SHOW_TENS | tens digit enabled (an=10)
  typedef enum logic {SHOW_ONES = 1'b0, SHOW_TENS = 1'b1} state_t;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    ones_r, tens, disp_ones, disp_tens;
  logic          carry_d, carry_d2, wrap_r;
  logic          carry_edge;
  logic [3:0]    digit;
  logic [6:0]    pattern, seg_nxt;
  logic [1:0]    an_nxt;

  assign carry_edge = carry_d & ~carry_d2;

  always_ff @(posedge cp) begin
    if (reset) begin
      ones_r    <= '0;
      carry_d   <= 1'b0;
      carry_d2  <= 1'b0;
      tens      <= '0;
      wrap_r    <= 1'b0;
      disp_ones <= '0;
      disp_tens <= '0;
    end else begin
      ones_r   <= ones_bcd;
      carry_d  <= carry_in;
      carry_d2 <= carry_d;
      wrap_r   <= 1'b0;
      if (carry_edge) begin
        if (tens == 4'd9) begin
          tens   <= '0;
          wrap_r <= 1'b1;
        end else begin
          tens <= tens + 4'd1;
        end
      end
      // Pre-increment tens is captured when a carry edge coincides with hold release.
      if (!hold) begin
        disp_ones <= ones_r;
        disp_tens <= tens;
      end
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      state <= SHOW_ONES;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      state_nxt = (state == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
    end
  end

  always_comb begin
    an_nxt = (state == SHOW_ONES) ? 2'b01 : 2'b10;
    digit  = (state == SHOW_ONES) ? disp_ones : disp_tens;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    seg_nxt = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      seg      <= SEG_OFF;
      an       <= 2'b00;
      bcd_err  <= 1'b0;
      tens_bcd <= '0;
      ovf      <= 1'b0;
    end else begin
      seg      <= seg_nxt;
      an       <= an_nxt;
      bcd_err  <= (disp_ones > 4'd9);
      tens_bcd <= tens;
      ovf      <= wrap_r;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver (REFRESH_DIV=4, active-low segments).
module tb_bcd_display_driver;

  logic       cp = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones_bcd = '0;
  logic       carry_in = 1'b0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] tens_bcd;
  logic       ovf;
  logic       bcd_err;

  int n_checks = 0;
  int n_fails  = 0;
  int ovf_seen = 0;
  int pc = 0;

  bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .cp(cp), .reset(reset), .ones_bcd(ones_bcd), .carry_in(carry_in), .hold(hold),
    .seg(seg), .an(an), .tens_bcd(tens_bcd), .ovf(ovf), .bcd_err(bcd_err)
  );

  always #5 cp = ~cp;

  // Cycles since reset release, used as the refresh reference.
  always @(posedge cp) pc <= reset ? 0 : pc + 1;
  always @(negedge cp) if (ovf) ovf_seen <= ovf_seen + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge cp);
  endtask

  task automatic wait_an(input logic [1:0] want);
    int k;
    k = 0;
    while (an !== want && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) chk("an_timeout", {30'd0, an}, {30'd0, want});
  endtask

  task automatic pulse();
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
    tick(2);
  endtask

  initial begin
    // 1: reset and refresh sequencing
    tick();
    chk("rst_an", an, 2'b00);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_tens", tens_bcd, 4'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", bcd_err, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("refresh_an", an, (((pc - 1) / 4) % 2) ? 2'b10 : 2'b01);
      chk("refresh_seg0", seg, 7'h40);
    end

    // 2: ones digit decode
    ones_bcd = 4'd7;
    tick(3);
    wait_an(2'b01);
    chk("ones7", seg, 7'h78);
    ones_bcd = 4'd9;
    tick(3);
    wait_an(2'b01);
    chk("ones9", seg, 7'h10);
    wait_an(2'b10);
    chk("tens0", seg, 7'h40);

    // 3: ten single-cycle carry pulses
    ovf_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      pulse();
      chk("tens_step", tens_bcd, i % 10);
      chk("ovf_step", ovf, (i == 10));
      tick();
    end
    chk("ovf_count", ovf_seen, 1);
    chk("ovf_clear", ovf, 1'b0);

    // 4: long carry counts once
    carry_in = 1'b1;
    tick(10);
    carry_in = 1'b0;
    tick(4);
    chk("long_carry", tens_bcd, 4'd1);

    // 5: hold freezes display while counting continues
    pulse();
    tick();
    ones_bcd = 4'd3;
    tick(4);
    hold = 1'b1;
    pulse(); tick();
    pulse(); tick();
    pulse(); tick();
    ones_bcd = 4'd8;
    tick(4);
    chk("hold_tens_live", tens_bcd, 4'd5);
    wait_an(2'b01);
    chk("hold_ones", seg, 7'h30);
    wait_an(2'b10);
    chk("hold_tens", seg, 7'h24);
    hold = 1'b0;
    tick(3);
    wait_an(2'b01);
    chk("rel_ones", seg, 7'h00);
    wait_an(2'b10);
    chk("rel_tens", seg, 7'h12);

    // 6: invalid ones digit, then reset mid-slot
    ones_bcd = 4'd12;
    tick(3);
    chk("err_set", bcd_err, 1'b1);
    wait_an(2'b01);
    chk("err_seg", seg, 7'h3F);
    wait_an(2'b10);
    chk("err_tens_slot", bcd_err, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_an", an, 2'b00);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_tens", tens_bcd, 4'd0);
    chk("mid_rst_err", bcd_err, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    ones_bcd = 4'd0;
    tick();
    chk("post_rst_an", an, 2'b01);
    chk("post_rst_seg", seg, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
